packet_rr_arbiter: RTL and testbench

PACKET_RR_ARBITER -- requirements
Module: packet_rr_arbiter

---
 rtl/packet_rr_arbiter.sv | 118 +++++++++++
 tb/tb_packet_rr_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// Round-robin arbiter for NREQ packet requesters feeding a single registered
// output slot, with a saturating count of completed output transfers.
module packet_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int SRCW = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      in_valid,
  output logic [NREQ-1:0]      in_ready,
  input  logic [12*NREQ-1:0]   in_pkt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_pkt,
  output logic [SRCW-1:0]      out_src,
  output logic [15:0]          xfer_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } occ_e;

  occ_e            state_q, state_d;
  logic [SRCW-1:0] ptr_q, ptr_d;
  logic [SRCW-1:0] src_q, src_d;
  logic [11:0]     pkt_q, pkt_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [SRCW-1:0] winner;
  logic [SRCW-1:0] idx;
  logic [11:0]     win_pkt;
  logic            found;
  logic            drain;
  logic            can_load;
  logic            accept;

  // Search starts at ptr and wraps at NREQ-1, so the requester just served
  // is checked last.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    found  = 1'b0;
    winner = '0;
    idx    = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == SRCW'(NREQ - 1)) ? '0 : idx + SRCW'(1);
    end
  end

  always_comb begin
    win_pkt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == SRCW'(i)) win_pkt = in_pkt[12*i +: 12];
    end
  end

  assign drain    = (state_q == FULL) && out_ready;
  assign can_load = (state_q == EMPTY) || out_ready;
  assign accept   = found && can_load && !reset;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (drain && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    if (accept) begin
      pkt_d = win_pkt;
      src_d = winner;
      ptr_d = (winner == SRCW'(NREQ - 1)) ? '0 : winner + SRCW'(1);
    end

    if (drain && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  // NOTE: the packet and source registers are reset along with the control
  // state so a discarded packet never reappears on out_pkt after reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      src_q   <= '0;
      pkt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      pkt_q   <= pkt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_pkt   = pkt_q;
  assign out_src   = src_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter: grant rotation, back-pressure, no-bubble
// reload, pointer wrap, counter saturation and mid-operation reset.
module tb_packet_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [47:0] in_pkt;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_pkt;
  logic [1:0]  out_src;
  logic [15:0] xfer_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] pk [4];
  logic [3:0]  onehot;
  int          w;

  packet_rr_arbiter #(.NREQ(4), .SRCW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pkt    (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pkt   (out_pkt),
    .out_src   (out_src),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge, once they settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pk[0] = 12'h3C0;
    pk[1] = 12'h5E1;
    pk[2] = 12'hA53;
    pk[3] = 12'h7F3;
    in_pkt    = {pk[3], pk[2], pk[1], pk[0]};
    reset     = 1'b1;
    in_valid  = 4'hF;
    out_ready = 1'b0;

    // Reset state; in_ready must stay low even with every requester valid.
    #1;
    check("rst_in_ready_pre", in_ready, 4'b0000);
    repeat (2) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pkt",   out_pkt,   12'h000);
    check("rst_out_src",   out_src,   2'd0);
    check("rst_xfer_cnt",  xfer_cnt,  16'd0);
    check("rst_in_ready",  in_ready,  4'b0000);

    // All four valid with out_ready held: grants 0,1,2,3,0, source one cycle later.
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      w      = g % 4;
      onehot = 4'b0001 << w;
      check("rr_grant", in_ready, onehot);
      tick();
      check("rr_valid", out_valid, 1'b1);
      check("rr_src",   out_src,   w);
      check("rr_pkt",   out_pkt,   pk[w]);
    end
    check("rr_cnt", xfer_cnt, 16'd4);
    in_valid = 4'b0000;
    #1;
    check("idle_in_ready", in_ready, 4'b0000);
    tick();
    check("rr_drain_valid", out_valid, 1'b0);
    check("rr_drain_cnt",   xfer_cnt,  16'd5);

    // out_ready while EMPTY must not count anything.
    tick();
    check("empty_ready_cnt", xfer_cnt, 16'd5);

    // Back-pressure: requester 2 with out_ready low for 5 cycles (ptr is 1).
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    #1;
    check("bp_grant", in_ready, 4'b0100);
    tick();
    repeat (5) begin
      check("bp_in_ready", in_ready,  4'b0000);
      check("bp_valid",    out_valid, 1'b1);
      check("bp_pkt",      out_pkt,   12'hA53);
      check("bp_src",      out_src,   2'd2);
      tick();
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    tick();
    check("bp_drain_valid", out_valid, 1'b0);
    check("bp_drain_cnt",   xfer_cnt,  16'd6);

    // No-bubble reload: FULL with requester 0, then drain and accept requester 1.
    out_ready = 1'b0;
    in_valid  = 4'b0001;
    tick();
    check("nb_first_src", out_src, 2'd0);
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    #1;
    check("nb_grant", in_ready, 4'b0010);
    tick();
    check("nb_valid", out_valid, 1'b1);
    check("nb_pkt",   out_pkt,   pk[1]);
    check("nb_src",   out_src,   2'd1);
    check("nb_cnt",   xfer_cnt,  16'd7);
    in_valid = 4'b0000;
    tick();
    check("nb_drain_valid", out_valid, 1'b0);
    check("nb_drain_cnt",   xfer_cnt,  16'd8);

    // Pointer wrap: after reset only requester 3, then 0 and 3 together.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrap_rst_cnt", xfer_cnt, 16'd0);
    in_valid  = 4'b1000;
    out_ready = 1'b1;
    #1;
    check("wrap_grant3", in_ready, 4'b1000);
    tick();
    check("wrap_src3", out_src, 2'd3);
    in_valid = 4'b1001;
    #1;
    check("wrap_grant0", in_ready, 4'b0001);
    tick();
    check("wrap_src0", out_src, 2'd0);
    check("wrap_pkt0", out_pkt, pk[0]);
    in_valid = 4'b0000;
    tick();
    check("wrap_cnt",   xfer_cnt,  16'd2);
    check("wrap_valid", out_valid, 1'b0);

    // Reset while FULL and stalled: packet discarded, arbitration restarts at 0.
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    tick();
    check("mid_full", out_valid, 1'b1);
    in_valid = 4'b1111;
    reset    = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 4'b0000);
    tick();
    reset    = 1'b0;
    in_valid = 4'b0110;
    #1;
    check("mid_valid", out_valid, 1'b0);
    check("mid_cnt",   xfer_cnt,  16'd0);
    check("mid_pkt",   out_pkt,   12'h000);
    check("mid_src",   out_src,   2'd0);
    check("mid_grant", in_ready,  4'b0010);
    tick();
    check("mid_src_after", out_src, 2'd1);

    // Saturation: continuous stream of 65535 cycles gives 65534 drains.
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    repeat (65535) tick();
    check("sat_fffe", xfer_cnt, 16'hFFFE);
    tick();
    check("sat_ffff", xfer_cnt, 16'hFFFF);
    repeat (2) tick();
    check("sat_hold", xfer_cnt, 16'hFFFF);
    in_valid = 4'b0000;
    tick();
    check("sat_final_cnt",   xfer_cnt,  16'hFFFF);
    check("sat_final_valid", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
